// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle LEGv8 control sequencer: FETCH/DECODE/EXEC/MEM/WB with a
// variable-latency data-memory handshake, sticky halt on illegal opcodes,
// and a retired-instruction counter.
module legv8_multicycle_ctrl (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] Inst,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic [1:0]  ImmSel,
  output logic        Reg2Loc,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [1:0]  ALUOp,
  output logic        Halted,
  output logic [31:0] InstRetired
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE, C_LDUR, C_STUR, C_CBZ, C_B, C_ILL
  } cls_t;

  state_t      state, nxt;
  cls_t        cls, dec_cls;
  logic [1:0]  imm_q;
  logic [31:0] cnt;

  // Only the opcode fields steer control; operand fields pass through the datapath.
  logic unused_inst;
  assign unused_inst = ^Inst[20:0];

  always_comb begin
    dec_cls = C_ILL;
    case (Inst[31:21])
      11'b11111000010: dec_cls = C_LDUR;
      11'b11111000000: dec_cls = C_STUR;
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: dec_cls = C_RTYPE;
      default: begin
        if (Inst[31:24] == 8'b10110100)    dec_cls = C_CBZ;
        else if (Inst[31:26] == 6'b000101) dec_cls = C_B;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= S_FETCH;
      cls   <= C_ILL;
      imm_q <= 2'b00;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) cls <= dec_cls;
      imm_q <= ImmSel;
      if (PCWrite) cnt <= cnt + 32'd1;
    end
  end

  always_comb begin
    nxt      = state;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    ImmSel   = imm_q;
    Reg2Loc  = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ALUOp    = 2'b00;
    Halted   = 1'b0;
    case (state)
      S_FETCH: begin
        IRWrite = 1'b1;
        nxt     = S_DECODE;
      end
      S_DECODE: nxt = (dec_cls == C_ILL) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (cls)
          C_RTYPE: begin
            ALUOp = 2'b10;
            nxt   = S_WB;
          end
          C_LDUR, C_STUR: begin
            ALUSrc = 1'b1;
            ImmSel = 2'b00;
            nxt    = S_MEM;
          end
          C_CBZ: begin
            Reg2Loc = 1'b1;
            ALUOp   = 2'b01;
            ImmSel  = 2'b10;
            PCWrite = 1'b1;
            PCSrc   = Zero;
            nxt     = S_FETCH;
          end
          C_B: begin
            ImmSel  = 2'b01;
            PCWrite = 1'b1;
            PCSrc   = 1'b1;
            nxt     = S_FETCH;
          end
          default: nxt = S_HALT;
        endcase
      end
      S_MEM: begin
        if (cls == C_LDUR) begin
          MemRead = 1'b1;
        end else begin
          MemWrite = 1'b1;
          Reg2Loc  = 1'b1;
        end
        // A store retires in the same cycle its write completes.
        if (MemReady) begin
          if (cls == C_LDUR) begin
            nxt = S_WB;
          end else begin
            PCWrite = 1'b1;
            nxt     = S_FETCH;
          end
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemtoReg = (cls == C_LDUR);
        PCWrite  = 1'b1;
        nxt      = S_FETCH;
      end
      S_HALT: Halted = 1'b1;
      default: nxt = S_FETCH;
    endcase
    // Reset masks every control immediately, even mid-transaction.
    if (Reset) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = 1'b0;
      ImmSel   = 2'b00;
      Reg2Loc  = 1'b0;
      ALUSrc   = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      ALUOp    = 2'b00;
      Halted   = 1'b0;
    end
  end

  assign InstRetired = Reset ? 32'd0 : cnt;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Bench for legv8_multicycle_ctrl: directed cases plus random instruction
// streams, each cycle compared to a per-instruction control trace model.
module tb_legv8_multicycle_ctrl;

  logic        CLK, Reset, Zero, MemReady;
  logic [31:0] Inst;
  logic        IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, MemtoReg;
  logic        RegWrite, MemRead, MemWrite, Halted;
  logic [1:0]  ImmSel, ALUOp;
  logic [31:0] InstRetired;

  int nchecks = 0;
  int nerr    = 0;
  logic [31:0] exp_cnt = 0;
  logic [1:0]  exp_imm = 2'b00;

  localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_B = 4, K_ILL = 5;

  legv8_multicycle_ctrl dut (
    .CLK(CLK), .Reset(Reset), .Inst(Inst), .Zero(Zero), .MemReady(MemReady),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .ImmSel(ImmSel),
    .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .ALUOp(ALUOp), .Halted(Halted),
    .InstRetired(InstRetired)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Control vector: IRWrite PCWrite PCSrc ImmSel[1:0] Reg2Loc ALUSrc MemtoReg
  //                 RegWrite MemRead MemWrite ALUOp[1:0] Halted
  function automatic logic [13:0] mk(logic irw, logic pcw, logic pcs, logic [1:0] imm,
                                     logic r2l, logic asrc, logic m2r, logic rw,
                                     logic mr, logic mw, logic [1:0] aop, logic h);
    return {irw, pcw, pcs, imm, r2l, asrc, m2r, rw, mr, mw, aop, h};
  endfunction

  function automatic logic [13:0] obs();
    return {IRWrite, PCWrite, PCSrc, ImmSel, Reg2Loc, ALUSrc, MemtoReg,
            RegWrite, MemRead, MemWrite, ALUOp, Halted};
  endfunction

  function automatic logic rb();
    return ($urandom & 32'd1) != 0;
  endfunction

  function automatic int classify(logic [31:0] i);
    if (i[31:21] == 11'b11111000010) return K_LD;
    if (i[31:21] == 11'b11111000000) return K_ST;
    if (i[31:21] == 11'b10001011000 || i[31:21] == 11'b11001011000 ||
        i[31:21] == 11'b10001010000 || i[31:21] == 11'b10101010000) return K_R;
    if (i[31:24] == 8'hB4) return K_CBZ;
    if (i[31:26] == 6'b000101) return K_B;
    return K_ILL;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: return {11'b10001011000, r[20:0]};
      1: return {11'b11001011000, r[20:0]};
      2: return {11'b10001010000, r[20:0]};
      3: return {11'b10101010000, r[20:0]};
      4: return {11'b11111000010, r[20:0]};
      5: return {11'b11111000000, r[20:0]};
      6: return {8'hB4, r[23:0]};
      default: return {6'b000101, r[25:0]};
    endcase
  endfunction

  // One clock: drive inputs just after the edge, sample 1 time unit later.
  task automatic cyc(input logic [31:0] inst, input logic z, input logic mrdy,
                     input logic [13:0] exp, input logic chk_imm, input string tag);
    logic [13:0] mask, o;
    @(posedge CLK);
    #1;
    Reset = 1'b0; Inst = inst; Zero = z; MemReady = mrdy;
    #1;
    mask = chk_imm ? 14'h3FFF : 14'h39FF;
    o = obs();
    nchecks++;
    assert ((o & mask) === (exp & mask))
      else begin nerr++; $error("FAIL %s ctl: got %h expected %h", tag, o & mask, exp & mask); end
    nchecks++;
    assert (InstRetired === exp_cnt)
      else begin nerr++; $error("FAIL %s retired: got %0d expected %0d", tag, InstRetired, exp_cnt); end
    if (exp[12]) exp_cnt++;
  endtask

  task automatic rst_cycles(input int n);
    logic [13:0] o;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      Reset = 1'b1; Zero = rb(); MemReady = rb();
      #1;
      o = obs();
      nchecks++;
      assert (o === 14'h0)
        else begin nerr++; $error("FAIL reset ctl: got %h expected %h", o, 14'h0); end
      nchecks++;
      assert (InstRetired === 32'd0)
        else begin nerr++; $error("FAIL reset retired: got %0d expected 0", InstRetired); end
    end
    exp_cnt = 0;
    exp_imm = 2'b00;
  endtask

  // zsel: 0/1 forces Zero during EXEC, 2 randomizes it.
  task automatic run_inst(input logic [31:0] inst, input int w, input int zsel);
    int k;
    logic z;
    k = classify(inst);
    cyc(inst, rb(), rb(), mk(1,0,0,exp_imm,0,0,0,0,0,0,2'b00,0), 1'b1, "fetch");
    cyc(inst, rb(), rb(), mk(0,0,0,exp_imm,0,0,0,0,0,0,2'b00,0), 1'b1, "decode");
    if (k == K_ILL) return;
    z = (zsel == 2) ? rb() : (zsel == 1);
    case (k)
      K_R: cyc(inst, z, rb(), mk(0,0,0,exp_imm,0,0,0,0,0,0,2'b10,0), 1'b1, "exec_r");
      K_LD, K_ST: begin
        exp_imm = 2'b00;
        cyc(inst, z, rb(), mk(0,0,0,2'b00,0,1,0,0,0,0,2'b00,0), 1'b1, "exec_mem");
      end
      K_CBZ: begin
        exp_imm = 2'b10;
        cyc(inst, z, rb(), mk(0,1,z,2'b10,1,0,0,0,0,0,2'b01,0), 1'b1, "exec_cbz");
      end
      default: begin
        exp_imm = 2'b01;
        cyc(inst, z, rb(), mk(0,1,1,2'b01,0,0,0,0,0,0,2'b00,0), 1'b1, "exec_b");
      end
    endcase
    if (k == K_LD || k == K_ST) begin
      for (int i = 0; i < w; i++)
        cyc(inst, rb(), 1'b0, (k == K_LD) ? mk(0,0,0,exp_imm,0,0,0,0,1,0,2'b00,0)
                                          : mk(0,0,0,exp_imm,1,0,0,0,0,1,2'b00,0),
            1'b1, "mem_wait");
      cyc(inst, rb(), 1'b1, (k == K_LD) ? mk(0,0,0,exp_imm,0,0,0,0,1,0,2'b00,0)
                                        : mk(0,1,0,exp_imm,1,0,0,0,0,1,2'b00,0),
          1'b1, "mem_done");
    end
    if (k == K_R || k == K_LD)
      cyc(inst, rb(), rb(), mk(0,1,0,exp_imm,0,0,(k == K_LD),1,0,0,2'b00,0), 1'b1, "wb");
  endtask

  initial begin
    Reset = 1'b1; Inst = 32'h0; Zero = 1'b0; MemReady = 1'b0;
    rst_cycles(2);

    run_inst(32'h8B020020, 0, 2);   // ADD
    run_inst(32'hF8408041, 2, 2);   // LDUR, two wait cycles
    run_inst(32'hB4000040, 0, 1);   // CBZ taken
    run_inst(32'hB4000040, 0, 0);   // CBZ not taken
    run_inst(32'h14000003, 0, 2);   // B
    run_inst(32'hF8008041, 0, 2);   // STUR, ready on entry

    for (int n = 0; n < 80; n++)
      run_inst(gen_inst(), $urandom_range(0, 3), 2);

    // Reset during the second MEM cycle of a store
    cyc(32'hF8008041, rb(), rb(), mk(1,0,0,exp_imm,0,0,0,0,0,0,2'b00,0), 1'b1, "st_fetch");
    cyc(32'hF8008041, rb(), rb(), mk(0,0,0,exp_imm,0,0,0,0,0,0,2'b00,0), 1'b1, "st_decode");
    exp_imm = 2'b00;
    cyc(32'hF8008041, rb(), rb(), mk(0,0,0,2'b00,0,1,0,0,0,0,2'b00,0), 1'b1, "st_exec");
    cyc(32'hF8008041, rb(), 1'b0, mk(0,0,0,2'b00,1,0,0,0,0,1,2'b00,0), 1'b1, "st_mem1");
    rst_cycles(1);
    run_inst(32'h8B020020, 0, 2);

    // Illegal opcode: sticky halt, no PC updates
    run_inst(32'hFFFFFFFF, 0, 2);
    for (int n = 0; n < 20; n++)
      cyc(32'hFFFFFFFF, rb(), rb(), mk(0,0,0,2'b00,0,0,0,0,0,0,2'b00,1), 1'b0, "halt");
    rst_cycles(1);

    for (int n = 0; n < 20; n++)
      run_inst(gen_inst(), $urandom_range(0, 3), 2);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
